// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and defaults for the two-source round-robin packet arbiter.
// Covers state encodings, default widths and a grant-state helper.
package mux2_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_BEATS = 16;
   localparam int DEF_CNT_W     = 5;

   // Maps a source index to the state that grants it.
   function automatic state_t grant_state(input logic src);
      return src ? ST_GRANT1 : ST_GRANT0;
   endfunction

endpackage

// File: rtl/mux2_rr_datapath.sv
// 2:1 mux carrying {last, data} from the selected source to the sink.
// Purely combinational; the select comes registered from the arbiter FSM.
module mux2_rr_datapath #(
   parameter int W = 9
) (
   input  logic         sel,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] y
);

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         assign y[gi] = sel ? in1[gi] : in0[gi];
      end
   endgenerate

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter for two sources sharing one sink.
// The grant is held for a full packet; the data path is the datapath mux.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BEATS = DEF_MAX_BEATS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_last,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_last,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy,
   output logic              err_long
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] SAT_CNT = {CNT_W{1'b1}};

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] beat_cnt;

   logic gnt0;
   logic gnt1;
   logic cur_src;
   logic cur_valid;
   logic other_valid;
   logic fire;

   logic [DATA_W:0] mux_out;

   mux2_rr_datapath #(
      .W (DATA_W + 1)
   ) u_datapath (
      .sel (sel),
      .in0 ({in0_last, in0_data}),
      .in1 ({in1_last, in1_data}),
      .y   (mux_out)
   );

   assign out_last = mux_out[DATA_W];
   assign out_data = mux_out[DATA_W-1:0];

   always_comb begin
      gnt0        = (state == ST_GRANT0);
      gnt1        = (state == ST_GRANT1);
      cur_src     = gnt1;
      cur_valid   = gnt1 ? in1_valid : in0_valid;
      other_valid = gnt1 ? in0_valid : in1_valid;
      out_valid   = (gnt0 & in0_valid) | (gnt1 & in1_valid);
      in0_ready   = gnt0 & out_ready;
      in1_ready   = gnt1 & out_ready;
      fire        = out_valid & out_ready;
   end

   // sel and busy are registered alongside state so they track it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sel        <= 1'b0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
         err_long   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in0_valid && (!in1_valid || last_grant)) begin
                  state <= ST_GRANT0;
                  sel   <= 1'b0;
                  busy  <= 1'b1;
               end else if (in1_valid) begin
                  state <= ST_GRANT1;
                  sel   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_GRANT0, ST_GRANT1: begin
               if (fire) begin
                  if (out_last) begin
                     beat_cnt   <= '0;
                     last_grant <= cur_src;
                     // Hand over without a bubble when the other side is waiting.
                     if (other_valid) begin
                        state <= grant_state(!cur_src);
                        sel   <= !cur_src;
                        busy  <= 1'b1;
                     end else if (cur_valid) begin
                        state <= grant_state(cur_src);
                        sel   <= cur_src;
                        busy  <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                        sel   <= 1'b0;
                        busy  <= 1'b0;
                     end
                  end else begin
                     if (beat_cnt != SAT_CNT) begin
                        beat_cnt <= beat_cnt + 1'b1;
                     end
                     if (beat_cnt >= MAX_CNT) begin
                        err_long <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               sel   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in0_valid = 1'b0;
   logic [7:0] in0_data = 8'h00;
   logic       in0_last = 1'b0;
   logic       in0_ready;
   logic       in1_valid = 1'b0;
   logic [7:0] in1_data = 8'h00;
   logic       in1_last = 1'b0;
   logic       in1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready = 1'b0;
   logic       sel;
   logic       busy;
   logic       err_long;

   int total = 0;
   int bad   = 0;

   mux2_rr_arbiter #(
      .DATA_W    (8),
      .MAX_BEATS (16),
      .CNT_W     (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy),
      .err_long  (err_long)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (in0_ready && in1_ready) begin
            bad++;
            $display("FAIL both_ready: in0_ready=%0b in1_ready=%0b required not both 1", in0_ready, in1_ready);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1;
      in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
      out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      total++;
      if ({in0_ready, in1_ready} !== 2'b00) begin bad++; $display("FAIL reset_readys: got %b want 00", {in0_ready, in1_ready}); end
      total++;
      if (sel !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_sel_busy: got sel=%0b busy=%0b want 0 0", sel, busy); end
      total++;
      if (err_long !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_long); end
      rst = 1'b0;
      step();
      total++;
      if (sel !== 1'b0 || busy !== 1'b1 || in0_ready !== 1'b1) begin
         bad++; $display("FAIL first_grant: got sel=%0b busy=%0b in0_ready=%0b want 0 1 1", sel, busy, in0_ready);
      end
      $display("test_reset: done total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_alternate();
      logic       exp_sel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_data [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
      in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b1;
      in1_valid = 1'b1; in1_data = 8'hB0; in1_last = 1'b1;
      out_ready = 1'b1;
      do_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || sel !== exp_sel[i] || out_data !== exp_data[i]) begin
            bad++;
            $display("FAIL alt_beat%0d: got valid=%0b sel=%0b data=%h want 1 %0b %h",
                     i, out_valid, sel, out_data, exp_sel[i], exp_data[i]);
         end
         step();
         case (i)
            0: in0_data = 8'hA1;
            1: in1_data = 8'hB1;
            2: in0_valid = 1'b0;
            default: in1_valid = 1'b0;
         endcase
         $display("test_alternate: beat %0d sel=%0b data=%h", i, exp_sel[i], exp_data[i]);
      end
   endtask

   task automatic test_hold_grant();
      in0_valid = 1'b1; in0_data = 8'h10; in0_last = 1'b0;
      in1_valid = 1'b0; in1_data = 8'h20; in1_last = 1'b1;
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      in0_data  = 8'h11;
      in1_valid = 1'b1;
      for (int b = 2; b <= 4; b++) begin
         @(negedge clk);
         total++;
         if (in1_ready !== 1'b0 || sel !== 1'b0 || out_data !== 8'(8'h0F + b)) begin
            bad++;
            $display("FAIL hold_beat%0d: got in1_ready=%0b sel=%0b data=%h want 0 0 %h",
                     b, in1_ready, sel, out_data, 8'(8'h0F + b));
         end
         step();
         if (b == 2) in0_data = 8'h12;
         if (b == 3) begin in0_data = 8'h13; in0_last = 1'b1; end
         if (b == 4) in0_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if (sel !== 1'b1 || out_data !== 8'h20 || in1_ready !== 1'b1) begin
         bad++; $display("FAIL hold_handover: got sel=%0b data=%h in1_ready=%0b want 1 20 1", sel, out_data, in1_ready);
      end
      $display("test_hold_grant: done total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_backpressure();
      in0_valid = 1'b0; in0_last = 1'b0;
      in1_valid = 1'b1; in1_data = 8'h5C; in1_last = 1'b0;
      out_ready = 1'b0;
      do_reset();
      step();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (in1_ready !== 1'b0 || out_data !== 8'h5C || sel !== 1'b1 || dut.beat_cnt !== 5'd0) begin
            bad++;
            $display("FAIL bp_stall%0d: got ready=%0b data=%h sel=%0b cnt=%0d want 0 5c 1 0",
                     c, in1_ready, out_data, sel, dut.beat_cnt);
         end
      end
      out_ready = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (dut.beat_cnt !== 5'd1 || sel !== 1'b1) begin
         bad++; $display("FAIL bp_release: got cnt=%0d sel=%0b want 1 1", dut.beat_cnt, sel);
      end
      $display("test_backpressure: done total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_long_packet();
      in0_valid = 1'b1; in0_data = 8'h40; in0_last = 1'b0;
      in1_valid = 1'b0; in1_data = 8'h41; in1_last = 1'b1;
      out_ready = 1'b1;
      do_reset();
      step();
      for (int k = 1; k <= 17; k++) begin
         step();
         total++;
         if (err_long !== (k == 17)) begin
            bad++; $display("FAIL long_beat%0d: got err=%0b want %0b", k, err_long, (k == 17));
         end
      end
      in0_last  = 1'b1;
      in1_valid = 1'b1;
      step();
      in0_valid = 1'b0;
      total++;
      if (err_long !== 1'b1 || dut.beat_cnt !== 5'd0 || sel !== 1'b1) begin
         bad++; $display("FAIL long_end: got err=%0b cnt=%0d sel=%0b want 1 0 1", err_long, dut.beat_cnt, sel);
      end
      step();
      in1_valid = 1'b0;
      total++;
      if (err_long !== 1'b1) begin bad++; $display("FAIL long_sticky: got %0b want 1", err_long); end
      do_reset();
      total++;
      if (err_long !== 1'b0) begin bad++; $display("FAIL long_clear: got %0b want 0", err_long); end
      $display("test_long_packet: done total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_reset_mid_packet();
      in0_valid = 1'b0; in0_data = 8'h60; in0_last = 1'b1;
      in1_valid = 1'b1; in1_data = 8'h31; in1_last = 1'b0;
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      in1_data  = 8'h32;
      in0_valid = 1'b1;
      @(negedge clk);
      total++;
      if (sel !== 1'b1 || in1_ready !== 1'b1) begin
         bad++; $display("FAIL mid_before: got sel=%0b in1_ready=%0b want 1 1", sel, in1_ready);
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in1_ready !== 1'b0 || sel !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_async: got valid=%0b in1_ready=%0b sel=%0b busy=%0b want 0 0 0 0",
                         out_valid, in1_ready, sel, busy);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if (sel !== 1'b0 || in0_ready !== 1'b1 || out_data !== 8'h60) begin
         bad++; $display("FAIL mid_after: got sel=%0b in0_ready=%0b data=%h want 0 1 60", sel, in0_ready, out_data);
      end
      $display("test_reset_mid_packet: done total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_hold_grant();
      test_backpressure();
      test_long_packet();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one downstream sink between two packet sources.
- Drives the select of a 2:1 data mux and gates valid/ready handshakes so only the granted source can transfer.
- Holds the grant for a whole packet, which can span several beats and ends on a beat with last=1.
- Sits in front of any shared single-port consumer. The data path is the internal 2:1 mux; all control lives in this block.

Parameters:
- DATA_W, 8: payload width of each input and of the output.
- MAX_BEATS, 16: packet-length limit. A packet longer than this sets the sticky error flag. It does not force release.
- CNT_W, 5: width of the beat counter. Must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in0_valid  input  1  source 0 has a beat.
- in0_data  input  DATA_W  source 0 payload.
- in0_last  input  1  marks the final beat of a source 0 packet.
- in0_ready  output  1  source 0 beat accepted this cycle.
- in1_valid  input  1  source 1 has a beat.
- in1_data  input  DATA_W  source 1 payload.
- in1_last  input  1  marks the final beat of a source 1 packet.
- in1_ready  output  1  source 1 beat accepted this cycle.
- out_valid  output  1  muxed valid to the sink.
- out_data  output  DATA_W  muxed payload.
- out_last  output  1  muxed last.
- out_ready  input  1  sink accepts a beat.
- sel  output  1  current grant: 0 means source 0, 1 means source 1. Registered.
- busy  output  1  high while a grant is held (any state other than IDLE).
- err_long  output  1  sticky: a packet exceeded MAX_BEATS beats.

Behaviour:
- Clocking and reset: single clock. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, sel=0, last_grant=1 (so source 0 wins the first tie).
  - beat_cnt=0, err_long=0, busy=0.
  - Because the state is IDLE: out_valid=0 and in0_ready=in1_ready=0.
- States: IDLE, GRANT0, GRANT1. sel is registered and equals 1 only in GRANT1.
- IDLE:
  - Outputs: out_valid=0, both readys=0, out_data/out_last = the mux of the current sel.
  - If only in0_valid is high, go to GRANT0. If only in1_valid is high, go to GRANT1.
  - If both are high, grant the source that is not last_grant.
  - This gives a 1-cycle arbitration bubble: the first beat transfers no earlier than the cycle after the request is seen in IDLE.
- GRANTn (combinational outputs):
  - out_valid = inN_valid, out_data = inN_data, out_last = inN_last.
  - inN_ready = out_ready. The other source's ready is 0.
- Handshake (a beat transfers when out_valid & out_ready):
  - On a non-last beat, increment beat_cnt (saturating at 2^CNT_W-1).
  - If beat_cnt reaches MAX_BEATS and a further beat transfers with last=0, set err_long. It stays set until rst.
- Packet end (handshake with last=1):
  - beat_cnt returns to 0 and last_grant becomes n.
  - Next state: if the other source's valid is high, go directly to GRANT(other) with no bubble. Else if inN_valid is high, go to GRANTn (re-grant the same source). Else go to IDLE.
- Grant stability:
  - The grant never changes mid-packet, whatever the other source does.
  - If the granted source drops valid mid-packet, the grant is held and out_valid=0.
- Back-pressure: if out_ready is low, no state change; the beat is stalled and the counter is unchanged.
- Single-beat packet (last=1 on the first beat): handled by the packet-end rule.
- Reset mid-packet: all registers return to their reset values immediately. The partial packet is abandoned; the sink sees out_valid drop asynchronously.
- Invariant: in0_ready and in1_ready are never both 1.

Decomposition:
- Shared include/package holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2;
  - the default DATA_W and MAX_BEATS.
- One natural sub-module: mux2_rr_datapath, a DATA_W+1-bit 2:1 mux that carries {last, data} and is selected by sel.
- The FSM, beat counter and ready/valid gating stay in the top module.

Test Plan:
- Reset then idle: rst=1 with both valids high -> out_valid=0, readys=0, sel=0, busy=0. On the first clock after rst drops, state=GRANT0.
- Simultaneous single-beat requests from both sources, out_ready=1, continuous: grants alternate 0,1,0,1 with no bubbles after the first. Sink receives 0xA0, 0xB0, 0xA1, 0xB1.
- Source 0 sends a 4-beat packet (last on beat 4); source 1 requests at beat 2:
  - in1_ready stays 0 until beat 4 transfers;
  - the next cycle has sel=1 and source 1's data on out_data.
- Back-pressure: in GRANT1, out_ready=0 for 3 cycles -> in1_ready=0, out_data holds 0x5C, beat_cnt is unchanged, no grant change.
- Long packet, MAX_BEATS=16: 17 non-last beats -> err_long rises after the 17th transfer, stays high through later packets, and clears only on rst.
- Reset mid-packet: assert rst during beat 2 of a source 1 packet -> out_valid, in1_ready and sel go to 0 asynchronously. After release, a pending source 0 request wins.
